// File: rtl/dcache_sa_wb_pkg.sv
// Shared definitions for the set-associative write-back data cache: FSM
// encoding, geometry helpers and the word-merge used on write hits.
package dcache_sa_wb_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  // Upper bounds for the merge helper; lines and words must fit within them.
  localparam int MAX_LINE_W = 1024;
  localparam int MAX_DATA_W = 256;

  function automatic int offs_f(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_f(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w_f(input int addr_w, input int line_w, input int sets);
    return addr_w - offs_f(line_w) - idx_f(sets);
  endfunction

  function automatic int words_f(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

  // Replace word 'sel' (data_w bits wide) of 'line' with 'word'.
  function automatic logic [MAX_LINE_W-1:0] merge_word(input logic [MAX_LINE_W-1:0] line,
                                                       input logic [MAX_DATA_W-1:0] word,
                                                       input int sel, input int data_w);
    logic [MAX_LINE_W-1:0] mask, ins;
    mask = ((MAX_LINE_W'(1) << data_w) - MAX_LINE_W'(1)) << (sel * data_w);
    ins  = MAX_LINE_W'(word) << (sel * data_w);
    return (line & ~mask) | (ins & mask);
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// Storage for one cache way: tag/data arrays plus resettable valid/dirty bits.
// Reads are asynchronous at the addressed set; writes update a whole entry.
module dcache_way_array
  import dcache_sa_wb_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int IDX    = 4,
  parameter int TAG_W  = 55,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX-1:0]    idx,
  input  logic              we,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data
);
  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[idx] <= wr_valid;
      dirty[idx] <= wr_dirty;
    end

  always_ff @(posedge clk)
    if (we) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];
endmodule

// File: rtl/dcache_sa_wb.sv
// N-way set-associative write-back / write-allocate data cache controller
// for the y86 memory stage, talking to a line-wide memory.
module dcache_sa_wb
  import dcache_sa_wb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_valid_i,
  input  logic              cpu_req_rw_i,
  input  logic [ADDR_W-1:0] cpu_req_addr_i,
  input  logic [DATA_W-1:0] cpu_req_data_i,
  output logic              cpu_res_ready_o,
  output logic [DATA_W-1:0] cpu_res_data_o,
  output logic              cpu_res_err_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_data_i,
  input  logic              mem_error_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);
  localparam int OFFS  = offs_f(LINE_W);
  localparam int IDX   = idx_f(SETS);
  localparam int TAG_W = tag_w_f(ADDR_W, LINE_W, SETS);
  localparam int WPL   = words_f(LINE_W, DATA_W);
  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_e state, state_nx;
  req_t   req;
  logic   refill, aborted, abort_now;
  logic [WAY_W-1:0] victim, pick_way, hit_way;
  logic [WAY_W-1:0] rr_ptr [SETS];
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic hit;

  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  int               word_sel;
  assign req_idx  = req.addr[OFFS +: IDX];
  assign req_tag  = req.addr[ADDR_W-1 -: TAG_W];
  assign word_sel = int'((req.addr >> BOFF) & ADDR_W'(WPL - 1));

  logic unused_ok;
  assign unused_ok = ^{req.addr[BOFF-1:0]};

  logic [WAYS-1:0]             rd_valid, rd_dirty, way_we;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][LINE_W-1:0] rd_data;
  logic              wr_en, wr_valid, wr_dirty;
  logic [WAY_W-1:0]  wr_way;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_data;

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign way_we[w] = wr_en && (wr_way == WAY_W'(w));
      dcache_way_array #(.SETS(SETS), .IDX(IDX), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
        .clk(clk_i), .rst_n(rst_n_i), .idx(req_idx), .we(way_we[w]),
        .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_tag(wr_tag), .wr_data(wr_data),
        .rd_valid(rd_valid[w]), .rd_dirty(rd_dirty[w]), .rd_tag(rd_tag[w]), .rd_data(rd_data[w])
      );
    end
  endgenerate

  // Lowest invalid way wins as victim; otherwise the set's round-robin pointer.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    pick_way = rr_ptr[req_idx];
    for (int w = 0; w < WAYS; w++)
      if (!hit && rd_valid[w] && rd_tag[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!rd_valid[w]) pick_way = WAY_W'(w);
  end

  assign abort_now = aborted || !cpu_req_valid_i;

  always_comb begin
    state_nx        = state;
    cpu_res_ready_o = 1'b0;
    cpu_res_data_o  = '0;
    cpu_res_err_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    wr_en           = 1'b0;
    wr_way          = victim;
    wr_valid        = 1'b1;
    wr_dirty        = 1'b0;
    wr_tag          = req_tag;
    wr_data         = mem_data_data_i;
    case (state)
      IDLE: if (cpu_req_valid_i) state_nx = COMPARE;
      COMPARE: begin
        if (!cpu_req_valid_i) state_nx = IDLE;
        else if (hit) begin
          cpu_res_ready_o = 1'b1;
          state_nx        = IDLE;
          if (req.rw) begin
            wr_en    = 1'b1;
            wr_way   = hit_way;
            wr_dirty = 1'b1;
            wr_data  = LINE_W'(merge_word(MAX_LINE_W'(rd_data[hit_way]), MAX_DATA_W'(req.data),
                                          word_sel, DATA_W));
          end else
            cpu_res_data_o = DATA_W'(rd_data[hit_way] >> (word_sel * DATA_W));
        end else
          state_nx = (rd_valid[pick_way] && rd_dirty[pick_way]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {rd_tag[victim], req_idx, {OFFS{1'b0}}};
        mem_req_data_o  = rd_data[victim];
        if (mem_data_ready_i) begin
          if (mem_error_i) begin
            cpu_res_ready_o = !abort_now;
            cpu_res_err_o   = !abort_now;
            state_nx        = IDLE;
          end else begin
            wr_en    = 1'b1;
            wr_tag   = rd_tag[victim];
            wr_data  = rd_data[victim];
            state_nx = abort_now ? IDLE : ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {req_tag, req_idx, {OFFS{1'b0}}};
        if (mem_data_ready_i) begin
          wr_en = 1'b1;
          if (mem_error_i) begin
            // the chosen victim is dropped rather than left half-evicted
            wr_valid        = 1'b0;
            wr_tag          = rd_tag[victim];
            wr_data         = rd_data[victim];
            cpu_res_ready_o = !abort_now;
            cpu_res_err_o   = !abort_now;
            state_nx        = IDLE;
          end else
            state_nx = abort_now ? IDLE : COMPARE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state    <= IDLE;
      req      <= '0;
      refill   <= 1'b0;
      aborted  <= 1'b0;
      victim   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (cpu_req_valid_i) begin
          req     <= '{cpu_req_rw_i, cpu_req_addr_i, cpu_req_data_i};
          refill  <= 1'b0;
          aborted <= 1'b0;
        end
        COMPARE: if (cpu_req_valid_i) begin
          if (hit) begin
            if (!refill) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
            victim   <= pick_way;
          end
        end
        WRITEBACK, ALLOCATE: begin
          if (!cpu_req_valid_i) aborted <= 1'b1;
          if (state == ALLOCATE && mem_data_ready_i && !mem_error_i) begin
            refill          <= 1'b1;
            rr_ptr[req_idx] <= (WAYS > 1) ? rr_ptr[req_idx] + 1'b1 : '0;
          end
        end
        default: ;
      endcase
    end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
endmodule

// File: tb/tb_dcache_sa_wb.sv
// Scoreboard bench for dcache_sa_wb: a latency-programmable line memory,
// a word-level reference image and a response queue checked on ready.
module tb_dcache_sa_wb;
  localparam int ADDR_W = 64, DATA_W = 64, LINE_W = 256, SETS = 16, WAYS = 2, CNT_W = 32;
  localparam int WPL = LINE_W / DATA_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic              cpu_valid = 1'b0, cpu_rw = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_res_ready_o, cpu_res_err_o;
  logic [DATA_W-1:0] cpu_res_data_o;
  logic              mem_req_valid_o, mem_req_rw_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [LINE_W-1:0] mem_req_data_o;
  logic              mem_ready = 1'b0, mem_error = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic [CNT_W-1:0]  hit_cnt_o, miss_cnt_o;

  dcache_sa_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .SETS(SETS),
                 .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_valid_i(cpu_valid), .cpu_req_rw_i(cpu_rw), .cpu_req_addr_i(cpu_addr),
    .cpu_req_data_i(cpu_wdata),
    .cpu_res_ready_o(cpu_res_ready_o), .cpu_res_data_o(cpu_res_data_o), .cpu_res_err_o(cpu_res_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_rw_o(mem_req_rw_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_data_ready_i(mem_ready), .mem_data_data_i(mem_rdata), .mem_error_i(mem_error),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference images
  logic [LINE_W-1:0] mem   [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_m [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return a ^ 64'h5A5A_0000_0000_0000;
  endfunction
  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] la);
    logic [LINE_W-1:0] l;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < WPL; w++) l[w*DATA_W +: DATA_W] = init_word(la + ADDR_W'(w * 8));
    return l;
  endfunction
  function automatic logic [DATA_W-1:0] ref_word(input logic [ADDR_W-1:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_word(a);
  endfunction
  function automatic logic [LINE_W-1:0] ref_line(input logic [ADDR_W-1:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*DATA_W +: DATA_W] = ref_word(la + ADDR_W'(w * 8));
    return l;
  endfunction

  // memory responder: acknowledges each request after mem_lat cycles
  typedef struct {logic rw; logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] data;} mreq_t;
  mreq_t mem_log[$];
  int mem_lat = 3, wcnt = 0;
  logic err_en = 1'b0;
  logic [ADDR_W-1:0] err_addr = 64'hFFFF_0000;

  always @(posedge clk) begin
    #1;
    mem_ready = 1'b0; mem_error = 1'b0; mem_rdata = '0;
    if (!mem_req_valid_o) wcnt = 0;
    else if (wcnt < mem_lat - 1) wcnt++;
    else begin
      wcnt = 0;
      mem_ready = 1'b1;
      mem_log.push_back('{mem_req_rw_o, mem_req_addr_o, mem_req_data_o});
      if (err_en && mem_req_addr_o == err_addr) mem_error = 1'b1;
      else if (mem_req_rw_o) mem[mem_req_addr_o] = mem_req_data_o;
      else mem_rdata = mem_line(mem_req_addr_o);
    end
  end

  // scoreboard of expected CPU responses
  typedef struct {logic [DATA_W-1:0] data; logic err; logic chk_data;} resp_t;
  resp_t sb_q[$];
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && cpu_res_ready_o) begin
      if (sb_q.size() == 0) chk("unexpected_ready", 1'b1, 1'b0);
      else begin
        r = sb_q.pop_front();
        chk("resp_err", cpu_res_err_o, r.err);
        if (r.chk_data) chk("resp_data", cpu_res_data_o, r.data);
      end
    end
  end

  int exp_hit = 0, exp_miss = 0;

  // kind: 0 hit, 1 clean miss, 2 dirty miss, 3 fill error
  task automatic access(input string tag, input logic rw, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input int kind);
    resp_t r;
    int cyc = 0, lat;
    lat = (kind == 0) ? 2 : (kind == 1) ? 3 + mem_lat : (kind == 2) ? 3 + 2 * mem_lat : 2 + mem_lat;
    r.err      = (kind == 3);
    r.chk_data = !rw || (kind == 3);
    r.data     = (kind == 3) ? '0 : ref_word(a);
    if (rw && kind != 3) ref_m[a] = wd;
    sb_q.push_back(r);
    if (kind == 0) exp_hit++; else exp_miss++;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    do begin @(negedge clk); cyc++; end while (!cpu_res_ready_o && cyc < 200);
    chk({tag, "_lat"}, cyc, lat);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    chk({tag, "_hit_cnt"}, hit_cnt_o, exp_hit);
    chk({tag, "_miss_cnt"}, miss_cnt_o, exp_miss);
  endtask

  task automatic expect_mem(input string tag, input logic rw, input logic [ADDR_W-1:0] a,
                            input logic cd, input logic [LINE_W-1:0] d);
    mreq_t m;
    if (mem_log.size() == 0) begin
      chk({tag, "_present"}, 1'b0, 1'b1);
      return;
    end
    m = mem_log.pop_front();
    chk({tag, "_rw"}, m.rw, rw);
    chk({tag, "_addr"}, m.addr, a);
    if (cd) chk({tag, "_data"}, m.data, d);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_cpu"}, {cpu_res_ready_o, cpu_res_err_o, cpu_res_data_o}, '0);
    chk({tag, "_memctl"}, {mem_req_valid_o, mem_req_rw_o, mem_req_addr_o}, '0);
    chk({tag, "_memdata"}, mem_req_data_o, '0);
    chk({tag, "_cnt"}, {hit_cnt_o, miss_cnt_o}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] l, wb_exp;
    int cyc;
    l = mem_line(64'h100);
    l[DATA_W-1:0] = 64'h11;
    mem[64'h100] = l;
    ref_m[64'h100] = 64'h11;

    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;

    // cold read, hit re-read, write hit, read-back
    access("cold_rd", 1'b0, 64'h100, '0, 1);
    expect_mem("cold_fill", 1'b0, 64'h100, 1'b0, '0);
    access("hit_rd", 1'b0, 64'h100, '0, 0);
    chk("hit_no_mem", mem_log.size(), 0);
    access("wr_hit", 1'b1, 64'h108, 64'hDEAD, 0);
    access("rd_108", 1'b0, 64'h108, '0, 0);
    chk("hit_no_mem2", mem_log.size(), 0);

    // fill both ways of set 0 dirty, then force an eviction
    access("wr_000", 1'b1, 64'h000, 64'hAAAA_0000, 1);
    expect_mem("fill_000", 1'b0, 64'h000, 1'b0, '0);
    access("wr_200", 1'b1, 64'h200, 64'hBBBB_0200, 1);
    expect_mem("fill_200", 1'b0, 64'h200, 1'b0, '0);
    wb_exp = ref_line(64'h000);
    access("rd_400", 1'b0, 64'h400, '0, 2);
    expect_mem("wb_000", 1'b1, 64'h000, 1'b1, wb_exp);
    expect_mem("fill_400", 1'b0, 64'h400, 1'b0, '0);
    access("rd_200", 1'b0, 64'h200, '0, 0);
    wb_exp = ref_line(64'h200);
    access("rd_000", 1'b0, 64'h000, '0, 2);
    expect_mem("wb_200", 1'b1, 64'h200, 1'b1, wb_exp);
    expect_mem("refill_000", 1'b0, 64'h000, 1'b0, '0);

    // fill error, then the same address must miss again
    err_en = 1'b1;
    access("err_rd", 1'b0, 64'hFFFF_0000, '0, 3);
    expect_mem("err_fill", 1'b0, 64'hFFFF_0000, 1'b0, '0);
    err_en = 1'b0;
    access("err_retry", 1'b0, 64'hFFFF_0000, '0, 1);
    expect_mem("retry_fill", 1'b0, 64'hFFFF_0000, 1'b0, '0);

    // abort during allocate: fill completes, no ready, line installed
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 64'h600;
    cyc = 0;
    while (!mem_req_valid_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk("abort_alloc_seen", {mem_req_valid_o, mem_req_rw_o}, 2'b10);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    exp_miss++;
    cyc = 0;
    while (mem_req_valid_o && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    expect_mem("abort_fill", 1'b0, 64'h600, 1'b0, '0);
    chk("abort_miss_cnt", miss_cnt_o, exp_miss);
    access("abort_hit", 1'b0, 64'h600, '0, 0);

    // reset in the middle of a write-back
    access("dirty_600", 1'b1, 64'h600, 64'h6666, 0);
    access("dirty_ff", 1'b1, 64'hFFFF_0000, 64'hFFFF, 0);
    mem_lat = 6;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 64'h800;
    cyc = 0;
    while (!(mem_req_valid_o && mem_req_rw_o) && cyc < 50) begin @(negedge clk); cyc++; end
    chk("wb_started", {mem_req_valid_o, mem_req_rw_o, mem_req_addr_o}, {2'b11, 64'hFFFF_0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    #1;
    chk_outs_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs_zero("post_rst");
    mem_log.delete();
    exp_hit = 0; exp_miss = 0; mem_lat = 3;
    access("rst_rd_100", 1'b0, 64'h100, '0, 1);
    expect_mem("rst_fill_100", 1'b0, 64'h100, 1'b0, '0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache controller for the y86 memory stage.
- Next generation of the single-configuration cache FSM: line width, set count, way count and data width are generalised.
- Adds per-set victim selection, dirty-line eviction, memory error reporting, request abort and hit/miss performance counters.
- Sits between the memory-stage request logic (read/write request plus `stall = cpu_req_valid_i & ~cpu_res_ready_o`) and the line-wide RAM model.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, CPU word width; multiple of 8, power of 2.
- LINE_W, 256, cache line / memory bus width; power-of-2 multiple of DATA_W.
- SETS, 16, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, ≥1.
- CNT_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- cpu_req_valid_i  in  1  request present; held until cpu_res_ready_o
- cpu_req_rw_i  in  1  1=write, 0=read
- cpu_req_addr_i  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- cpu_req_data_i  in  DATA_W  write data
- cpu_res_ready_o  out  1  one-cycle completion pulse
- cpu_res_data_o  out  DATA_W  read data, valid with ready
- cpu_res_err_o  out  1  memory error, valid with ready
- mem_req_valid_o  out  1  line request
- mem_req_rw_o  out  1  1=write-back, 0=fill
- mem_req_addr_o  out  ADDR_W  line-aligned address
- mem_req_data_o  out  LINE_W  victim line
- mem_data_ready_i  in  1  memory completes current request
- mem_data_data_i  in  LINE_W  fill data
- mem_error_i  in  1  valid with mem_data_ready_i; address fault
- hit_cnt_o  out  CNT_W  hit count
- miss_cnt_o  out  CNT_W  miss count

Behaviour:

Reset:
- Asynchronous reset forces state=IDLE and clears all valid bits, dirty bits, victim pointers and counters.
- All outputs are 0 during and after reset.
- Any in-flight memory request is dropped; memory must tolerate this.

Address split:
- OFFS=log2(LINE_W/8), IDX=log2(SETS), tag=addr[ADDR_W-1:OFFS+IDX].
- Word select = addr[OFFS-1:log2(DATA_W/8)].

States:
- IDLE:
  - valid=1 → COMPARE (request registered).
- COMPARE:
  - Tag match on any valid way → hit.
    - Read: cpu_res_data_o = selected word.
    - Write: merge word, set dirty.
    - Assert ready for 1 cycle, hit_cnt++, → IDLE.
  - Miss:
    - miss_cnt++.
    - Pick victim: lowest-index invalid way, else the set's round-robin pointer.
    - Victim valid & dirty → WRITEBACK, else → ALLOCATE.
- WRITEBACK:
  - Drive mem_req_valid_o=1, rw=1, addr={victim tag, index, 0}, data=victim line; hold until mem_data_ready_i.
  - Then clear dirty → ALLOCATE.
- ALLOCATE:
  - Drive valid=1, rw=0, addr = request line-aligned; hold until mem_data_ready_i.
  - On ready with no error: install line (valid=1, dirty=0, tag), advance the set pointer (mod WAYS) → COMPARE, which then hits.
  - The re-compare after a fill does not increment hit_cnt.

Latency:
- Hit: ready asserts 2 cycles after valid rises (IDLE, COMPARE).
- Clean miss: 2 + fill latency + 1.
- Dirty miss: adds the write-back latency.

Memory error on a fill:
- Assert ready and cpu_res_err_o for 1 cycle, data=0, → IDLE.
- No line is installed and the victim is left invalid if it was evicted.

Memory error on a write-back:
- Same response as a fill error; the dirty bit is retained.

Abort:
- If valid drops in COMPARE, no ready is asserted and no state is updated → IDLE.
- If valid drops in WRITEBACK/ALLOCATE, the memory transaction completes, the line is installed, no ready is asserted → IDLE.

Handshake rules:
- mem_req_* are stable while mem_req_valid_o=1 and not yet acknowledged.
- mem_req_valid_o deasserts the cycle after mem_data_ready_i.

Counters:
- Wrap on overflow.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, COMPARE, WRITEBACK, ALLOCATE);
  - derived widths (OFFS, IDX, TAG_W, WORDS_PER_LINE) computed as functions of the parameters;
  - the word-merge function.
- One sub-module, dcache_way_array:
  - tag/valid/dirty/data storage for one way;
  - asynchronous read, synchronous write, async clear of valid/dirty.
  - It is instantiated WAYS times.

Test Plan:
- Default params; read 0x100 cold → one ALLOCATE with mem addr 0x100; fill word0=0x11 → ready with data 0x11, miss_cnt=1; re-read 0x100 → ready on 2nd cycle, hit_cnt=1, no mem request.
- Write 0xDEAD to 0x108 after fill → hit, dirty set; read 0x108 → 0xDEAD.
- WAYS=2, SETS=16: dirty lines at 0x000 and 0x200, then read 0x400 → WRITEBACK addr 0x000 with the dirty line data, then ALLOCATE 0x400; re-read 0x200 hits.
- mem_error_i on fill for 0xFFFF_0000 → ready=1, err=1, data=0; next read of the same address misses again.
- Drop valid during ALLOCATE → fill completes, no ready; later read of the same line hits.
- Assert rst_n_i low mid-WRITEBACK → all outputs 0, counters 0; next read of a previous line misses.
